// File: rtl/vga_timing_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package  : vga_pkg
// Desc     : Default 640x480@60 timing constants, FSM state type, total helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package vga_pkg;

    localparam int c_h_active_def = 640;
    localparam int c_h_fp_def     = 16;
    localparam int c_h_sync_def   = 96;
    localparam int c_h_bp_def     = 48;
    localparam int c_v_active_def = 480;
    localparam int c_v_fp_def     = 10;
    localparam int c_v_sync_def   = 2;
    localparam int c_v_bp_def     = 33;
    localparam int c_lock_dly_def = 16;
    localparam int c_cw_def       = 10;

    typedef enum logic [0:0] {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } vga_state_e;

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Interface: vga_timing_ctrl_if
// Desc     : Raster timing bundle from the timing generator to pixel gen / DAC.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface vga_timing_ctrl_if #(
    parameter int CW = vga_pkg::c_cw_def
);
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          blank_n;
    logic          sync_n;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          running;

    modport master (
        output hsync, vsync, video_on, blank_n, sync_n,
        output x, y, line_start, frame_start, running
    );

    modport slave (
        input hsync, vsync, video_on, blank_n, sync_n,
        input x, y, line_start, frame_start, running
    );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : sync_2ff
// Desc     : Two-flop synchronizer for asynchronous level inputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : vga_timing_ctrl
// Desc     : VGA raster timing generator gated by a stable PLL lock.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active_def,
    parameter int H_FP     = c_h_fp_def,
    parameter int H_SYNC   = c_h_sync_def,
    parameter int H_BP     = c_h_bp_def,
    parameter int V_ACTIVE = c_v_active_def,
    parameter int V_FP     = c_v_fp_def,
    parameter int V_SYNC   = c_v_sync_def,
    parameter int V_BP     = c_v_bp_def,
    parameter bit SYNC_POL = 1'b0,
    parameter int LOCK_DLY = c_lock_dly_def,
    parameter int CW       = c_cw_def
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    vga_timing_ctrl_if.master vga
);

    localparam int c_h_total = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_cw_need = $clog2((c_h_total > c_v_total) ? c_h_total : c_v_total);
    localparam int c_lw      = $clog2(LOCK_DLY) + 1;

    localparam logic [CW-1:0]   c_h_max    = CW'(c_h_total - 1);
    localparam logic [CW-1:0]   c_v_max    = CW'(c_v_total - 1);
    localparam logic [CW-1:0]   c_h_act    = CW'(H_ACTIVE);
    localparam logic [CW-1:0]   c_v_act    = CW'(V_ACTIVE);
    localparam logic [CW-1:0]   c_hs_start = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]   c_hs_end   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0]   c_vs_start = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]   c_vs_end   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_lw-1:0] c_lock_max = c_lw'(LOCK_DLY - 1);

    generate
        if (CW < c_cw_need) begin : g_cw_check
            $error("vga_timing_ctrl: CW=%0d cannot hold the line/frame totals (need %0d)",
                   CW, c_cw_need);
        end
    endgenerate

    logic            w_lock_s;
    vga_state_e      r_state;
    vga_state_e      w_state_nxt;
    logic [c_lw-1:0] r_lock_cnt;
    logic [c_lw-1:0] w_lock_cnt_nxt;
    logic [CW-1:0]   r_h_cnt;
    logic [CW-1:0]   r_v_cnt;
    logic [CW-1:0]   w_h_nxt;
    logic [CW-1:0]   w_v_nxt;

    logic            w_run_nxt;
    logic            w_hs_act;
    logic            w_vs_act;
    logic            w_video_nxt;

    logic            r_hsync;
    logic            r_vsync;
    logic            r_video_on;
    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_y;
    logic            r_line_start;
    logic            r_frame_start;
    logic            r_running;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (locked),
        .o_q (w_lock_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= WAIT_LOCK;
            r_lock_cnt <= '0;
            r_h_cnt    <= '0;
            r_v_cnt    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_h_cnt    <= w_h_nxt;
            r_v_cnt    <= w_v_nxt;
        end
    end

    // Lock loss wins over counter advance, so a broken frame is dropped at once.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_h_nxt        = r_h_cnt;
        w_v_nxt        = r_v_cnt;
        case (r_state)
            WAIT_LOCK: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (!w_lock_s) begin
                    w_lock_cnt_nxt = '0;
                end else if (r_lock_cnt == c_lock_max) begin
                    w_state_nxt    = RUN;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + c_lw'(1);
                end
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt    = WAIT_LOCK;
                    w_lock_cnt_nxt = '0;
                    w_h_nxt        = '0;
                    w_v_nxt        = '0;
                end else if (r_h_cnt == c_h_max) begin
                    w_h_nxt = '0;
                    w_v_nxt = (r_v_cnt == c_v_max) ? '0 : r_v_cnt + CW'(1);
                end else begin
                    w_h_nxt = r_h_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt    = WAIT_LOCK;
                w_lock_cnt_nxt = '0;
                w_h_nxt        = '0;
                w_v_nxt        = '0;
            end
        endcase
    end

    // Decode from next-state counters so registered outputs line up with h/v.
    assign w_run_nxt   = (w_state_nxt == RUN);
    assign w_hs_act    = w_run_nxt && (w_h_nxt >= c_hs_start) && (w_h_nxt < c_hs_end);
    assign w_vs_act    = w_run_nxt && (w_v_nxt >= c_vs_start) && (w_v_nxt < c_vs_end);
    assign w_video_nxt = w_run_nxt && (w_h_nxt < c_h_act) && (w_v_nxt < c_v_act);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_video_nxt;
            r_x           <= w_video_nxt ? w_h_nxt : '0;
            r_y           <= w_video_nxt ? w_v_nxt : '0;
            r_line_start  <= w_run_nxt && (w_h_nxt == '0);
            r_frame_start <= w_run_nxt && (w_h_nxt == '0) && (w_v_nxt == '0);
            r_running     <= w_run_nxt;
        end
    end

    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.video_on    = r_video_on;
    assign vga.blank_n     = r_video_on;
    assign vga.sync_n      = 1'b1;
    assign vga.x           = r_x;
    assign vga.y           = r_y;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;
    assign vga.running     = r_running;

endmodule
`default_nettype wire

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Raster timing generator for the 640x480@60 VGA output. It is clocked by the 25.175 MHz pixel clock from the PLL and uses the PLL lock flag to gate operation. It produces hsync/vsync, blanking and pixel coordinates for the downstream pixel generator and the video DAC. It idles until the PLL has been stably locked, then scans frames continuously.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
LOCK_DLY, 16, consecutive synchronized-locked cycles required before scanning
CW, 10, coordinate/counter width

Ports:
clk  input  1  pixel clock (PLL outclk_0)
rst  input  1  asynchronous, active-low reset; deasserted synchronously by the integrator
locked  input  1  PLL lock flag; treated as asynchronous
hsync  output  1  horizontal sync, polarity SYNC_POL
vsync  output  1  vertical sync, polarity SYNC_POL
video_on  output  1  high inside the active 640x480 region
blank_n  output  1  DAC blank, equals video_on
sync_n  output  1  DAC composite sync, constant 1
x  output  CW  pixel column; 0 when not video_on
y  output  CW  pixel row; 0 when not video_on
line_start  output  1  one-cycle pulse at h_cnt==0 while RUN
frame_start  output  1  one-cycle pulse at h_cnt==0 && v_cnt==0 while RUN
running  output  1  high in RUN state

Behaviour:
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Lock synchronizer: 2-flop synchronizer on locked, giving lock_s.
- FSM states:
  - WAIT_LOCK: lock_cnt counts up while lock_s=1 and clears on lock_s=0. When lock_cnt reaches LOCK_DLY-1 with lock_s=1, go to RUN; h_cnt and v_cnt load 0 on that same edge.
  - RUN: if lock_s=0, go to WAIT_LOCK and clear lock_cnt. This exit takes priority over counter advance.
- Counters (RUN only):
  - h_cnt increments each cycle; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1 when h_cnt wraps.
  - In WAIT_LOCK both counters are held at 0.
- Output decode: all outputs are registered and decoded from the next-state counter values, so they align with h_cnt/v_cnt after each edge (no extra latency).
  - hsync asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync asserted when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - video_on = RUN && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- Outputs in WAIT_LOCK: hsync and vsync deasserted (level !SYNC_POL); video_on, blank_n, x, y, line_start, frame_start and running all 0.
- Reset (rst=0, asynchronous): state WAIT_LOCK; synchronizer, lock_cnt and counters 0; outputs take their WAIT_LOCK values.
- Reset or lock loss mid-frame: the frame is abandoned. A fresh frame starts at (0,0) after re-lock plus LOCK_DLY cycles.
- Lock glitch shorter than LOCK_DLY during WAIT_LOCK: lock_cnt restarts from 0.
- Width rule: CW must hold H_TOTAL-1 and V_TOTAL-1. Defaults require CW>=10; flag a simulation-time error otherwise.

Decomposition:
- Package vga_pkg: default 640x480 timing constants, the state enum (WAIT_LOCK, RUN), and a localparam function computing the totals.
- Sub-module sync_2ff for the lock synchronizer (reusable for other async inputs).
- Counters, FSM and decode stay in vga_timing_ctrl.

Test Plan:
- Reset/lock-up: rst=0 then 1 with locked=1 -> running rises 2+LOCK_DLY cycles after rst release (18 cycles); hsync=vsync=1 and x=y=0 before that; frame_start pulses on the first RUN cycle.
- Line timing: in RUN, measure one line -> 800 clk per line_start; video_on high 640 cycles; hsync low from h_cnt 656 to 751 (96 cycles); x runs 0..639.
- Frame timing: run 2 frames -> frame_start period 420000 cycles; vsync low for exactly 1600 cycles (lines 490-491); y runs 0..479; exactly 307200 video_on cycles per frame.
- Lock loss mid-frame: drop locked at (x=320, y=200) -> within 2-3 cycles running=0, outputs idle, counters 0. Re-assert locked -> frame_start after 2+LOCK_DLY cycles at (0,0).
- Lock glitch: in WAIT_LOCK, pulse locked low for 1 cycle at lock_cnt=10 -> count restarts; running rises only after 16 further consecutive locked cycles.
- Async reset mid-line: assert rst between edges at h_cnt=700 -> outputs go idle immediately, without waiting for a clk edge; recovery matches the first scenario.
